// File: rtl/shl_arbiter_if.sv
// Bundle of the requester-side and shared-L_shl-side signals of the
// L_shl arbiter. The slave modport is the arbiter's view; the master
// modport is the environment (requester FSMs plus the shared L_shl unit).
interface shl_arbiter_if;
   // Requester side (four requesters packed side by side)
   logic [3:0]   reqReady;
   logic [127:0] reqVar1;
   logic [63:0]  reqNumShift;
   logic [3:0]   reqDone;
   logic [31:0]  reqResult;

   // Shared L_shl side
   logic [31:0]  L_shlOutVar1;
   logic [15:0]  L_shlNumShiftOut;
   logic         L_shlReady;
   logic [31:0]  L_shlIn;
   logic         L_shlDone;

   // Status
   logic         busy;
   logic         protoErr;

   modport slave (
      input  reqReady, reqVar1, reqNumShift, L_shlIn, L_shlDone,
      output reqDone, reqResult, L_shlOutVar1, L_shlNumShiftOut, L_shlReady,
             busy, protoErr
   );

   modport master (
      output reqReady, reqVar1, reqNumShift, L_shlIn, L_shlDone,
      input  reqDone, reqResult, L_shlOutVar1, L_shlNumShiftOut, L_shlReady,
             busy, protoErr
   );
endinterface

// File: rtl/shl_arbiter.sv
// Round-robin arbiter sharing one multi-cycle L_shl unit among four
// requester FSMs. Single-cycle requests are latched into per-requester
// holding registers, issued one at a time, and the done pulse plus result
// are steered back to whichever requester owns the outstanding operation.
module shl_arbiter #(
   parameter int NREQ = 4
) (
   input  logic         clk,
   input  logic         reset,
   shl_arbiter_if.slave bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] pending_q, pending_d;
   logic [31:0]     var1_q   [NREQ];
   logic [15:0]     nshift_q [NREQ];
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [1:0]      owner_q, owner_d;
   logic            proto_err_q, proto_err_d;

   logic            done_fire;
   logic [NREQ-1:0] clr_vec;
   logic [NREQ-1:0] load_vec;
   logic [NREQ-1:0] drop_vec;

   logic            win_valid;
   logic [1:0]      win_idx;

   logic            l_shl_ready;
   logic [31:0]     l_shl_var1;
   logic [15:0]     l_shl_nshift;

   // A done only counts while an operation is outstanding; a done seen in
   // IDLE (stray, or arriving after a reset) is simply ignored.
   assign done_fire = (state_q == ST_WAIT) && bus.L_shlDone;

   // Per-requester capture decisions. A new request is accepted when the
   // slot is free or is being freed this very cycle (set wins over clear);
   // otherwise it is dropped and flagged as a protocol error.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign clr_vec[gi]  = done_fire && (owner_q == 2'(gi));
         assign load_vec[gi] = bus.reqReady[gi] && (!pending_q[gi] || clr_vec[gi]);
         assign drop_vec[gi] = bus.reqReady[gi] && pending_q[gi] && !clr_vec[gi];

         // Next pending bit: load sets, completion clears, else hold.
         always_comb begin
            pending_d[gi] = pending_q[gi];
            if (load_vec[gi]) begin
               pending_d[gi] = 1'b1;
            end else if (clr_vec[gi]) begin
               pending_d[gi] = 1'b0;
            end
         end
      end
   endgenerate

   assign proto_err_d = proto_err_q | (|drop_vec);

   // Operand holding registers, loaded only on an accepted request.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (reset) begin
            var1_q[i]   <= '0;
            nshift_q[i] <= '0;
         end else if (load_vec[i]) begin
            var1_q[i]   <= bus.reqVar1[32*i +: 32];
            nshift_q[i] <= bus.reqNumShift[16*i +: 16];
         end
      end
   end

   // Round-robin pick: first pending requester at or after rr_ptr_q,
   // wrapping. Scanning from the far end lets the nearest one win last.
   always_comb begin
      logic [1:0] cand;
      win_valid = 1'b0;
      win_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = rr_ptr_q + 2'(k);
         if (pending_q[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and L_shl issue logic. The issue pulse and operands are
   // combinational in IDLE so the grant goes out in the same cycle the
   // winner is selected.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      l_shl_ready  = 1'b0;
      l_shl_var1   = '0;
      l_shl_nshift = '0;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               l_shl_ready  = 1'b1;
               l_shl_var1   = var1_q[win_idx];
               l_shl_nshift = nshift_q[win_idx];
               owner_d      = win_idx;
               rr_ptr_d     = win_idx + 2'd1;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.L_shlDone) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State, arbitration bookkeeping and sticky error register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Result is a straight pass-through of L_shlIn so the owner samples it
   // exactly as it would sample the unit directly; zero otherwise.
   assign bus.reqDone          = clr_vec;
   assign bus.reqResult        = done_fire ? bus.L_shlIn : 32'h0;
   assign bus.L_shlReady       = l_shl_ready;
   assign bus.L_shlOutVar1     = l_shl_var1;
   assign bus.L_shlNumShiftOut = l_shl_nshift;
   assign bus.busy             = (state_q == ST_WAIT) || (|pending_q);
   assign bus.protoErr         = proto_err_q;

endmodule

// File: tb/tb_shl_arbiter.sv
// Bench for shl_arbiter: a simple shifter model with programmable latency
// stands in for the shared L_shl unit. Table vectors cover single and
// multi-request batches; hand sequences cover protocol errors, a request
// coinciding with a done, and reset while an operation is outstanding.
module tb_shl_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   shl_arbiter_if bus ();

   shl_arbiter #(.NREQ(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         rst;
      logic [3:0]   mask;
      logic [127:0] var1;
      logic [63:0]  nsh;
      int           lat;
      int           n;
      logic [7:0]   order;  // 2 bits per grant, first grant in [1:0]
      logic [127:0] res;    // expected result per requester
   } vec_t;

   vec_t vecs [6];

   // Shifter model state
   int          lat = 2;
   int          cnt = 0;
   logic [31:0] sh_res;

   // Observed events
   logic [47:0] iss_q [$];
   logic [3:0]  dbit_q [$];
   logic [31:0] dres_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Shared-unit model: acts at the falling edge, returns operand << shift
   // lat cycles after seeing the issue pulse.
   initial begin
      bus.L_shlDone = 1'b0;
      bus.L_shlIn   = 32'h0;
      forever begin
         @(negedge clk);
         bus.L_shlDone = 1'b0;
         bus.L_shlIn   = 32'h0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.L_shlDone = 1'b1;
               bus.L_shlIn   = sh_res;
            end
         end
         if (bus.L_shlReady) begin
            sh_res = bus.L_shlOutVar1 << bus.L_shlNumShiftOut[4:0];
            cnt    = lat;
         end
      end
   end

   // One cycle: sample just after the falling edge and log events.
   task automatic cyc();
      @(negedge clk);
      #1;
      if (bus.L_shlReady) iss_q.push_back({bus.L_shlNumShiftOut, bus.L_shlOutVar1});
      if (bus.reqDone != 4'h0) begin
         dbit_q.push_back(bus.reqDone);
         dres_q.push_back(bus.reqResult);
         check("done_onehot", 128'($onehot(bus.reqDone)), 128'd1);
         check("done_vs_ready", 128'(bus.L_shlReady), 128'd0);
      end
   endtask

   task automatic clear_logs();
      iss_q.delete();
      dbit_q.delete();
      dres_q.delete();
   endtask

   task automatic do_reset();
      bus.reqReady = 4'h0;
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (bus.busy && t < 200) begin
         cyc();
         t++;
      end
      check({name, "_timeout"}, 128'(t < 200), 128'd1);
   endtask

   task automatic run_batch(input vec_t v, input int id);
      int r;
      if (v.rst) do_reset();
      clear_logs();
      lat = v.lat;
      bus.reqVar1     = v.var1;
      bus.reqNumShift = v.nsh;
      bus.reqReady    = v.mask;
      cyc();
      bus.reqReady    = 4'h0;
      wait_idle($sformatf("v%0d", id));
      check($sformatf("v%0d_issues", id), 128'(iss_q.size()), 128'(v.n));
      check($sformatf("v%0d_dones", id), 128'(dbit_q.size()), 128'(v.n));
      for (int k = 0; k < v.n; k++) begin
         r = int'(v.order[2*k +: 2]);
         if (k < iss_q.size())
            check($sformatf("v%0d_issue%0d", id, k), 128'(iss_q[k]),
                  128'({v.nsh[16*r +: 16], v.var1[32*r +: 32]}));
         if (k < dbit_q.size()) begin
            check($sformatf("v%0d_dbit%0d", id, k), 128'(dbit_q[k]), 128'(4'b0001 << r));
            check($sformatf("v%0d_dres%0d", id, k), 128'(dres_q[k]), 128'(v.res[32*r +: 32]));
         end
      end
      check($sformatf("v%0d_ready_idle", id), 128'(bus.L_shlReady), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int t;
      int n_done, n_ready, n_busy;

      vecs[0] = '{rst:1'b0, mask:4'b0001,
                  var1:{96'h0, 32'h00001234}, nsh:{48'h0, 16'd3},
                  lat:2, n:1, order:8'h00,
                  res:{96'h0, 32'h000091A0}};
      vecs[1] = '{rst:1'b1, mask:4'b1111,
                  var1:{32'h80000044, 32'h00000033, 32'h00000022, 32'h00000011},
                  nsh:{16'd4, 16'd3, 16'd2, 16'd1},
                  lat:1, n:4, order:{2'd3, 2'd2, 2'd1, 2'd0},
                  res:{32'h00000440, 32'h00000198, 32'h00000088, 32'h00000022}};
      vecs[2] = '{rst:1'b0, mask:4'b0100,
                  var1:{32'h0, 32'h0000ABCD, 64'h0}, nsh:{16'h0, 16'd8, 32'h0},
                  lat:3, n:1, order:{6'h0, 2'd2},
                  res:{32'h0, 32'h00ABCD00, 64'h0}};
      vecs[3] = '{rst:1'b0, mask:4'b1001,
                  var1:{32'hFFFFFFFF, 64'h0, 32'h00000001}, nsh:{16'd0, 32'h0, 16'd31},
                  lat:2, n:2, order:{4'h0, 2'd0, 2'd3},
                  res:{32'hFFFFFFFF, 64'h0, 32'h80000000}};
      vecs[4] = '{rst:1'b0, mask:4'b0110,
                  var1:{32'h0, 32'h00000007, 32'h0F0F0F0F, 32'h0},
                  nsh:{16'h0, 16'd16, 16'd4, 16'h0},
                  lat:5, n:2, order:{4'h0, 2'd2, 2'd1},
                  res:{32'h0, 32'h00070000, 32'hF0F0F0F0, 32'h0}};
      // Run after reset-mid-WAIT: pointer must be back at 0, so 0 before 3.
      vecs[5] = '{rst:1'b0, mask:4'b1001,
                  var1:{32'h00000010, 64'h0, 32'h00000020}, nsh:{16'd1, 32'h0, 16'd2},
                  lat:1, n:2, order:{4'h0, 2'd3, 2'd0},
                  res:{32'h00000020, 64'h0, 32'h00000080}};

      reset           = 1'b1;
      bus.reqReady    = 4'h0;
      bus.reqVar1     = '0;
      bus.reqNumShift = '0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();

      check("rst_reqDone", 128'(bus.reqDone), 128'd0);
      check("rst_reqResult", 128'(bus.reqResult), 128'd0);
      check("rst_ready", 128'(bus.L_shlReady), 128'd0);
      check("rst_var1", 128'(bus.L_shlOutVar1), 128'd0);
      check("rst_nshift", 128'(bus.L_shlNumShiftOut), 128'd0);
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_protoErr", 128'(bus.protoErr), 128'd0);

      for (int i = 0; i < 5; i++) begin
         run_batch(vecs[i], i);
         check($sformatf("v%0d_protoErr", i), 128'(bus.protoErr), 128'd0);
      end

      // Protocol violation: requester 1 re-requests while still pending.
      clear_logs();
      lat = 3;
      bus.reqVar1     = {64'h0, 32'h00000005, 32'h0};
      bus.reqNumShift = {32'h0, 16'd2, 16'h0};
      bus.reqReady    = 4'b0010;
      cyc();
      bus.reqVar1[63:32]     = 32'h00000099;
      bus.reqNumShift[31:16] = 16'd1;
      bus.reqReady           = 4'b0010;
      cyc();
      bus.reqReady = 4'h0;
      wait_idle("perr");
      check("perr_issues", 128'(iss_q.size()), 128'd1);
      check("perr_dones", 128'(dbit_q.size()), 128'd1);
      if (dbit_q.size() > 0) begin
         check("perr_dbit", 128'(dbit_q[0]), 128'(4'b0010));
         check("perr_dres", 128'(dres_q[0]), 128'h14);
      end
      check("perr_flag", 128'(bus.protoErr), 128'd1);

      // Coincident: requester 2 asks in the cycle requester 0's done returns.
      clear_logs();
      lat = 2;
      bus.reqVar1     = {32'h0, 32'h00000777, 32'h0, 32'h00000100};
      bus.reqNumShift = {16'h0, 16'd5, 16'h0, 16'd4};
      bus.reqReady    = 4'b0001;
      cyc();
      bus.reqReady = 4'h0;
      found = 1'b0;
      t = 0;
      while (!found && t < 20) begin
         cyc();
         t++;
         if (bus.reqDone != 4'h0) found = 1'b1;
      end
      check("coin_done_seen", 128'(found), 128'd1);
      check("coin_dbit", 128'(bus.reqDone), 128'(4'b0001));
      check("coin_dres", 128'(bus.reqResult), 128'h1000);
      bus.reqReady = 4'b0100;
      cyc();
      bus.reqReady = 4'h0;
      check("coin_issue_ready", 128'(bus.L_shlReady), 128'd1);
      check("coin_issue_var1", 128'(bus.L_shlOutVar1), 128'h777);
      check("coin_issue_nsh", 128'(bus.L_shlNumShiftOut), 128'd5);
      wait_idle("coin");
      check("coin_dones", 128'(dbit_q.size()), 128'd2);
      if (dres_q.size() == 2) check("coin_dres2", 128'(dres_q[1]), 128'hEEE0);
      check("coin_sticky", 128'(bus.protoErr), 128'd1);

      // Reset while an operation is outstanding, with another one pending.
      clear_logs();
      lat = 10;
      bus.reqVar1     = {32'h0, 32'h00000009, 32'h00000003, 32'h0};
      bus.reqNumShift = {16'h0, 16'd1, 16'd1, 16'h0};
      bus.reqReady    = 4'b0010;
      cyc();
      bus.reqReady    = 4'b0100;
      cyc();
      bus.reqReady    = 4'h0;
      cyc();
      check("rw_busy_before", 128'(bus.busy), 128'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      clear_logs();
      n_done = 0; n_ready = 0; n_busy = 0;
      repeat (12) begin
         cyc();
         if (bus.reqDone != 4'h0) n_done++;
         if (bus.L_shlReady) n_ready++;
         if (bus.busy) n_busy++;
      end
      check("rw_no_done", 128'(n_done), 128'd0);
      check("rw_no_ready", 128'(n_ready), 128'd0);
      check("rw_not_busy", 128'(n_busy), 128'd0);
      check("rw_result", 128'(bus.reqResult), 128'd0);
      check("rw_protoErr", 128'(bus.protoErr), 128'd0);
      run_batch(vecs[5], 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shl_arbiter.md
Name: shl_arbiter

Overview:
- Shares one multi-cycle L_shl unit among up to NREQ FSM requesters (syn_filt and sibling G.729 blocks).
- Each requester keeps its existing L_shlReady / L_shlDone / L_shlIn handshake unchanged.
- The arbiter captures single-cycle requests into per-requester holding registers, issues them round-robin, and routes the result and done pulse back to the issuing requester.

Parameters:
NREQ, 4, number of requesters (ports sized for 4; fixed in this revision)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
reqReady  in  4  bit i: one-cycle request pulse from requester i; operands valid that cycle
reqVar1  in  128  requester i operand at bits [32i+31:32i]
reqNumShift  in  64  requester i shift count at bits [16i+15:16i]
reqDone  out  4  bit i: one-cycle done pulse to requester i
reqResult  out  32  shifted result, valid when any reqDone bit is high
L_shlOutVar1  out  32  operand to shared L_shl
L_shlNumShiftOut  out  16  shift count to shared L_shl
L_shlReady  out  1  one-cycle issue pulse to L_shl
L_shlIn  in  32  L_shl result
L_shlDone  in  1  L_shl done
busy  out  1  high in WAIT or when any request is pending
protoErr  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset: all outputs 0, pending[3:0]=0, holding registers 0, state=IDLE, rrPtr=0, owner=0.
- Capture: a reqReady[i] pulse loads var1[i] and nshift[i] and sets pending[i] at the clock edge.
  - If pending[i] is already set and is not being cleared that cycle, the request is dropped and protoErr is set.
  - If a set and a clear of pending[i] coincide, the set wins and the new operands are loaded.
- Arbitration: round-robin. Search order is rrPtr, rrPtr+1, ... wrapping mod 4. After reset, requester 0 has highest priority.
- State machine (2 states):
  - IDLE:
    - If pending≠0, select winner w combinationally.
    - Same cycle: drive L_shlReady=1, L_shlOutVar1=var1[w], L_shlNumShiftOut=nshift[w].
    - Register owner=w and rrPtr=(w+1) mod 4; go WAIT.
    - L_shlDone received in IDLE is ignored (stray or late done).
  - WAIT:
    - L_shlReady=0 and operand outputs=0.
    - Stay in WAIT while L_shlDone=0; there is no timeout.
    - When L_shlDone=1, in the same cycle:
      - reqDone[owner]=1 and reqResult=L_shlIn (combinational pass-through, so a requester samples it exactly as it would sample L_shlIn).
      - Clear pending[owner] (subject to the set-wins rule); go IDLE.
- Outputs when no done is being returned: reqResult=0.
- Latency: a request in cycle T issues no earlier than T+1. Minimum turnaround is 1 IDLE cycle per grant. Back-to-back grants are separated by exactly one IDLE cycle after each done.
- A request from requester j≠owner that coincides with L_shlDone is captured normally.
- At most one reqDone bit is high in any cycle.
- L_shlReady and a reqDone bit are never high in the same cycle.
- Widths: no arithmetic on data; all data is passed through bit-exact. rrPtr and owner are 2 bits and wrap naturally.
- Reset mid-operation (in WAIT):
  - All state is cleared and pending requests are discarded.
  - A subsequent L_shlDone is ignored in IDLE.
  - Requesters are also reset by the same reset.

Test Plan:
- Single request: reqReady=0001, reqVar1[31:0]=0x00001234, nshift=3. Expect L_shlReady one cycle later with 0x00001234/3. Bench shifter returns 0x000091A0 after 2 cycles. Expect reqDone=0001 and reqResult=0x000091A0 in that cycle, then busy=0.
- Contention: reqReady=1111 in one cycle with distinct operands. Expect issues in order 0,1,2,3, each done routed only to its own bit, exactly 4 reqDone pulses, protoErr=0.
- Fairness: after a grant to 2, assert requests 0 and 3 together. Expect 3 granted before 0.
- Protocol violation: requester 1 pulses reqReady twice while pending. Expect the second request dropped, protoErr=1 sticky, and one done to requester 1 carrying the first operands.
- Coincident events: requester 2 requests in the same cycle requester 0's done arrives. Expect reqDone=0001 that cycle, then IDLE issues requester 2 on the next cycle.
- Reset mid-WAIT: reset asserted while awaiting done, then a late L_shlDone=1. Expect all outputs 0, no reqDone pulse, state IDLE, rrPtr=0.
